// File: rtl/sram_spi_reader.sv
// SPI mode-0 slave streaming DATA_W-bit words from the line-buffer SRAM; STATUS command (0x05) under SPI_STATUS_CMD_EN.
// Latency: spi_miso follows a spi_clk fall by 3 clk; first word is loaded RD_LAT+1 clk after the address completes.
// Backpressure: none; the host paces everything through spi_clk and must respect the minimum phase lengths.
module sram_spi_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] rdaddr,
    input  logic [DATA_W-1:0] rddata,
    input  logic              busy,
    input  logic              frame_done,
    output logic              reading
);
    localparam int LW = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_FILL,
        S_STREAM,
        S_IGNORE
`ifdef SPI_STATUS_CMD_EN
        , S_STATUS
`endif
    } state_t;

    state_t state, state_nx;

    logic [1:0]        sclk_sync, cs_sync, mosi_sync;
    logic              sclk_d, cs_d;
    logic              sclk_rise, sclk_fall, cs_hi, cs_fall, mosi_s;
    logic [4:0]        bit_cnt;
    logic [6:0]        sh_in;
    logic [7:0]        byte_in;
    logic              byte_last;
    logic [ADDR_W-9:0] addr_hi;
    logic [ADDR_W-1:0] nxt;
    logic [DATA_W-1:0] sh_out, pf_dat;
    logic [LW-1:0]     lat_cnt;
    logic              lat_done, pf_pend, sampled, frame_ready, stream_entry;

    // Sync chain resets low so a cs held low across reset never looks like a fresh cs fall.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_d    <= sclk_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sclk_rise    = sclk_sync[1] & ~sclk_d;
    assign sclk_fall    = ~sclk_sync[1] & sclk_d;
    assign cs_hi        = cs_sync[1];
    assign cs_fall      = cs_d & ~cs_sync[1];
    assign mosi_s       = mosi_sync[1];
    assign byte_in      = {sh_in, mosi_s};
    assign byte_last    = (bit_cnt == 5'd7);
    assign lat_done     = (lat_cnt == LW'(RD_LAT));
    assign stream_entry = (state == S_FILL) && (state_nx == S_STREAM);

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_hi) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (cs_fall) state_nx = S_CMD;
                S_CMD: begin
                    if (sclk_rise && byte_last) begin
                        if (byte_in == 8'h03)      state_nx = S_ADDR_HI;
`ifdef SPI_STATUS_CMD_EN
                        else if (byte_in == 8'h05) state_nx = S_STATUS;
`endif
                        else                       state_nx = S_IGNORE;
                    end
                end
                S_ADDR_HI: if (sclk_rise && byte_last) state_nx = S_ADDR_LO;
                S_ADDR_LO: if (sclk_rise && byte_last) state_nx = S_FILL;
                S_FILL:    if (lat_done) state_nx = S_STREAM;
                default:   ;
            endcase
        end
    end

    always_comb begin
        reading  = (state == S_STREAM);
        spi_miso = 1'b0;
        if (state == S_STREAM) spi_miso = sh_out[DATA_W-1];
`ifdef SPI_STATUS_CMD_EN
        if (state == S_STATUS) spi_miso = sh_out[DATA_W-1];
`endif
    end

    // A fall only shifts once a rise has sampled the current bit, so the fall that
    // trails the last command/address rise never skips the first output bit.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bit_cnt     <= '0;
            sh_in       <= '0;
            addr_hi     <= '0;
            rdaddr      <= '0;
            nxt         <= '0;
            sh_out      <= '0;
            pf_dat      <= '0;
            lat_cnt     <= '0;
            pf_pend     <= 1'b0;
            sampled     <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            frame_ready <= frame_done | (frame_ready & ~stream_entry);
            if (cs_hi || state == S_IDLE) begin
                bit_cnt <= '0;
                sh_in   <= '0;
                sampled <= 1'b0;
                pf_pend <= 1'b0;
            end else begin
                case (state)
                    S_CMD, S_ADDR_HI, S_ADDR_LO: begin
                        if (sclk_rise) begin
                            sh_in   <= byte_in[6:0];
                            bit_cnt <= byte_last ? 5'd0 : bit_cnt + 5'd1;
                            if (byte_last && state == S_ADDR_HI) addr_hi <= byte_in[ADDR_W-9:0];
                            if (byte_last && state == S_ADDR_LO) begin
                                rdaddr  <= {addr_hi, byte_in};
                                lat_cnt <= '0;
                            end
`ifdef SPI_STATUS_CMD_EN
                            if (byte_last && state == S_CMD && byte_in == 8'h05)
                                sh_out <= {busy, frame_ready, {(DATA_W-2){1'b0}}};
`endif
                        end
                    end
                    S_FILL: begin
                        if (lat_done) begin
                            sh_out  <= rddata;
                            nxt     <= rdaddr + ADDR_W'(1);
                            bit_cnt <= '0;
                            sampled <= 1'b0;
                        end else begin
                            lat_cnt <= lat_cnt + LW'(1);
                        end
                    end
                    S_STREAM: begin
                        if (pf_pend) begin
                            if (lat_done) begin
                                pf_dat  <= rddata;
                                pf_pend <= 1'b0;
                            end else begin
                                lat_cnt <= lat_cnt + LW'(1);
                            end
                        end
                        if (sclk_rise) sampled <= 1'b1;
                        if (sclk_fall && sampled) begin
                            sampled <= 1'b0;
                            if (bit_cnt == 5'(DATA_W - 1)) begin
                                sh_out  <= pf_dat;
                                nxt     <= nxt + ADDR_W'(1);
                                bit_cnt <= '0;
                            end else begin
                                sh_out  <= {sh_out[DATA_W-2:0], 1'b0};
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                            if (bit_cnt == 5'd0) begin
                                rdaddr  <= nxt;
                                lat_cnt <= '0;
                                pf_pend <= 1'b1;
                            end
                        end
                    end
`ifdef SPI_STATUS_CMD_EN
                    S_STATUS: begin
                        if (sclk_rise) sampled <= 1'b1;
                        if (sclk_fall && sampled) begin
                            sampled <= 1'b0;
                            sh_out  <= {sh_out[DATA_W-2:0], 1'b0};
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

`ifndef SPI_STATUS_CMD_EN
    logic status_unused;
    assign status_unused = busy ^ frame_ready;
`endif

endmodule

// File: tb/tb_sram_spi_reader.sv
// Directed bench for sram_spi_reader: bit-banged SPI host plus an RD_LAT-deep SRAM model.
module tb_sram_spi_reader;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;
    localparam int PH     = 8;

`ifdef SPI_STATUS_CMD_EN
    localparam logic [7:0] ST_FR   = 8'h40;
    localparam logic [7:0] ST_BUSY = 8'h80;
`else
    localparam logic [7:0] ST_FR   = 8'h00;
    localparam logic [7:0] ST_BUSY = 8'h00;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;
    logic spi_clk = 1'b0;
    logic cs = 1'b1;
    logic spi_mosi = 1'b0;
    logic busy = 1'b0;
    logic frame_done = 1'b0;
    logic spi_miso, reading;
    logic [ADDR_W-1:0] rdaddr;
    logic [DATA_W-1:0] rddata;
    logic [DATA_W-1:0] mem [0:4095];
    logic [DATA_W-1:0] pipe0, pipe1;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe0 <= mem[rdaddr];
        pipe1 <= pipe0;
    end
    assign rddata = pipe1;

    sram_spi_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .res(res), .spi_clk(spi_clk), .cs(cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .rdaddr(rdaddr), .rddata(rddata), .busy(busy),
        .frame_done(frame_done), .reading(reading)
    );

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (PH) @(negedge clk);
        r = spi_miso;
        spi_clk = 1'b1;
        repeat (PH) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        rx = '0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx = {rx[6:0], b};
        end
    endtask

    task automatic spi_word(output logic [15:0] rx);
        logic b;
        rx = '0;
        for (int i = 0; i < 16; i++) begin
            spi_bit(1'b0, b);
            rx = {rx[14:0], b};
        end
    endtask

    task automatic spi_begin();
        cs = 1'b0;
        repeat (PH) @(negedge clk);
    endtask

    task automatic spi_end();
        repeat (PH) @(negedge clk);
        cs = 1'b1;
        repeat (PH) @(negedge clk);
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        n_chk++; if (rdaddr !== 12'h000) begin n_fail++; $display("FAIL reset_rdaddr: got %h want 000", rdaddr); end
        n_chk++; if (reading !== 1'b0) begin n_fail++; $display("FAIL reset_reading: got %b want 0", reading); end
        res = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ignore();
        logic [7:0] r;
        logic [15:0] w;
        spi_begin();
        spi_byte(8'h7E, r);
        n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL ignore_cmd_miso: got %h want 00", r); end
        spi_word(w);
        n_chk++; if (w !== 16'h0000) begin n_fail++; $display("FAIL ignore_data_miso: got %h want 0000", w); end
        n_chk++; if (reading !== 1'b0) begin n_fail++; $display("FAIL ignore_reading: got %b want 0", reading); end
        n_chk++; if (rdaddr !== 12'h000) begin n_fail++; $display("FAIL ignore_rdaddr: got %h want 000", rdaddr); end
        spi_end();
    endtask

    task automatic test_read();
        logic [7:0] r0, r1, r2;
        logic [15:0] w;
        spi_begin();
        spi_byte(8'h03, r0);
        spi_byte(8'h01, r1);
        spi_byte(8'h23, r2);
        n_chk++; if ({r0, r1, r2} !== 24'h0) begin n_fail++; $display("FAIL read_hdr_miso: got %h want 000000", {r0, r1, r2}); end
        spi_word(w);
        n_chk++; if (w !== 16'hA5C3) begin n_fail++; $display("FAIL read_word0: got %h want A5C3", w); end
        n_chk++; if (reading !== 1'b1) begin n_fail++; $display("FAIL read_reading0: got %b want 1", reading); end
        spi_word(w);
        n_chk++; if (w !== 16'h0FF0) begin n_fail++; $display("FAIL read_word1: got %h want 0FF0", w); end
        n_chk++; if (reading !== 1'b1) begin n_fail++; $display("FAIL read_reading1: got %b want 1", reading); end
        n_chk++; if (rdaddr !== 12'h125) begin n_fail++; $display("FAIL read_prefetch_addr: got %h want 125", rdaddr); end
        spi_end();
        n_chk++; if (reading !== 1'b0) begin n_fail++; $display("FAIL read_reading_end: got %b want 0", reading); end
    endtask

    task automatic test_wrap();
        logic [7:0] r;
        logic [15:0] w;
        spi_begin();
        spi_byte(8'h03, r);
        spi_byte(8'hFF, r);
        spi_byte(8'hFF, r);
        spi_word(w);
        n_chk++; if (w !== 16'h1234) begin n_fail++; $display("FAIL wrap_word_fff: got %h want 1234", w); end
        spi_word(w);
        n_chk++; if (w !== 16'hBEEF) begin n_fail++; $display("FAIL wrap_word_000: got %h want BEEF", w); end
        spi_word(w);
        n_chk++; if (w !== 16'h5A5A) begin n_fail++; $display("FAIL wrap_word_001: got %h want 5A5A", w); end
        spi_end();
    endtask

    task automatic test_status();
        logic [7:0] r;
        logic [15:0] w;
        @(negedge clk) frame_done = 1'b1;
        @(negedge clk) frame_done = 1'b0;
        spi_begin();
        spi_byte(8'h05, r);
        spi_byte(8'h00, r);
        n_chk++; if (r !== ST_FR) begin n_fail++; $display("FAIL status_frame_ready: got %h want %h", r, ST_FR); end
        spi_end();
        spi_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        spi_word(w);
        n_chk++; if (w !== 16'hC3A5) begin n_fail++; $display("FAIL status_read_word: got %h want C3A5", w); end
        spi_end();
        spi_begin();
        spi_byte(8'h05, r);
        spi_byte(8'h00, r);
        n_chk++; if (r !== 8'h00) begin n_fail++; $display("FAIL status_cleared: got %h want 00", r); end
        spi_end();
        busy = 1'b1;
        spi_begin();
        spi_byte(8'h05, r);
        spi_byte(8'h00, r);
        n_chk++; if (r !== ST_BUSY) begin n_fail++; $display("FAIL status_busy: got %h want %h", r, ST_BUSY); end
        spi_end();
        busy = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic [4:0] p;
        logic b;
        logic [15:0] w;
        spi_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        p = '0;
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b0, b);
            p = {p[3:0], b};
        end
        n_chk++; if (p !== 5'b11000) begin n_fail++; $display("FAIL abort_partial: got %b want 11000", p); end
        spi_end();
        spi_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        spi_word(w);
        n_chk++; if (w !== 16'hC3A5) begin n_fail++; $display("FAIL abort_restart_word0: got %h want C3A5", w); end
        spi_word(w);
        n_chk++; if (w !== 16'h7001) begin n_fail++; $display("FAIL abort_restart_word1: got %h want 7001", w); end
        spi_end();
    endtask

    task automatic test_res_mid();
        logic [7:0] r;
        logic [4:0] p;
        logic b;
        logic [15:0] w;
        spi_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h01, r);
        spi_byte(8'h23, r);
        p = '0;
        for (int i = 0; i < 5; i++) begin
            spi_bit(1'b0, b);
            p = {p[3:0], b};
        end
        n_chk++; if (p !== 5'b10100) begin n_fail++; $display("FAIL resmid_partial: got %b want 10100", p); end
        repeat (PH) @(negedge clk);
        n_chk++; if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL resmid_pre_miso: got %b want 1", spi_miso); end
        n_chk++; if (reading !== 1'b1) begin n_fail++; $display("FAIL resmid_pre_reading: got %b want 1", reading); end
        res = 1'b0;
        #1;
        n_chk++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL resmid_miso: got %b want 0", spi_miso); end
        n_chk++; if (reading !== 1'b0) begin n_fail++; $display("FAIL resmid_reading: got %b want 0", reading); end
        @(negedge clk) res = 1'b1;
        spi_word(w);
        n_chk++; if (w !== 16'h0000) begin n_fail++; $display("FAIL resmid_no_output: got %h want 0000", w); end
        n_chk++; if (reading !== 1'b0) begin n_fail++; $display("FAIL resmid_reading_after: got %b want 0", reading); end
        spi_end();
        spi_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h01, r);
        spi_byte(8'h24, r);
        spi_word(w);
        n_chk++; if (w !== 16'h0FF0) begin n_fail++; $display("FAIL resmid_recover: got %h want 0FF0", w); end
        spi_end();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h123] = 16'hA5C3;
        mem[12'h124] = 16'h0FF0;
        mem[12'hFFF] = 16'h1234;
        mem[12'h000] = 16'hBEEF;
        mem[12'h001] = 16'h5A5A;
        mem[12'h010] = 16'hC3A5;
        mem[12'h011] = 16'h7001;
        test_reset();
        test_ignore();
        test_read();
        test_wrap();
        test_status();
        test_abort();
        test_res_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
